// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead subtractor.
// Imported by the group cell and the pipeline top.
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic borrow;
        logic ovf;
        logic zero;
    } flags_t;

    // Signed overflow of a - b: operands of opposite sign and result sign differs from a.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_pipe_subtractor_if.sv
// Operand/result handshake bundle for cla_pipe_subtractor.
// The slave modport is the subtractor; the master modport is the producer/consumer side.
interface cla_pipe_subtractor_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_diff, out_borrow, out_ovf, out_zero
    );

endinterface

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group: sum, carry out and group generate/propagate.
// The subtrahend arrives already inverted, so g = a & ~b and p = a ^ ~b.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] nb,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               cout,
    output logic               g,
    output logic               p
);

    logic [GROUP_W-1:0] gi;
    logic [GROUP_W-1:0] pi;
    logic               c1;
    logic               c2;
    logic               c3;

    assign gi = a & nb;
    assign pi = a ^ nb;

    // Every internal carry is expanded straight from cin, with no ripple between bits.
    assign c1 = gi[0] | (pi[0] & cin);
    assign c2 = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
    assign c3 = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);

    assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p = &pi;

    assign cout = g | (p & cin);
    assign sum  = pi ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_pipe_subtractor.sv
// Pipelined A - B (A + ~B + 1), one 4-bit lookahead group per stage, with valid/ready
// handshake on both sides and borrow/overflow/zero flags registered alongside the result.
module cla_pipe_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    cla_pipe_subtractor_if.slave bus
);

    localparam int STAGES = WIDTH / GROUP_W;

    if ((WIDTH % GROUP_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("cla_pipe_subtractor: WIDTH must be a multiple of 4 and at least 8");
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] nb;
        logic             carry;
        logic             a_msb;
        logic             b_msb;
    } token_t;

    token_t stage_q [STAGES];
    token_t stage_d [STAGES];
    flags_t flags_q;
    flags_t flags_d;
    logic   adv;

    // The whole pipe moves together; a held result freezes every stage behind it.
    assign adv          = ~stage_q[STAGES-1].valid | bus.out_ready;
    assign bus.in_ready = adv & ~rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        token_t             src;
        logic [WIDTH-1:0]   diff_next;
        logic [GROUP_W-1:0] grp_sum;
        logic               grp_cout;
        logic               grp_g;
        logic               grp_p;
        logic               carry_next;

        if (k == 0) begin : g_first
            always_comb begin
                src       = '0;
                src.valid = bus.in_valid;
                src.a     = bus.in_a;
                src.nb    = ~bus.in_b;
                src.carry = 1'b1;
                src.a_msb = bus.in_a[WIDTH-1];
                src.b_msb = bus.in_b[WIDTH-1];
            end
        end else begin : g_next
            assign src = stage_q[k-1];
        end

        cla_group4 u_group (
            .a    (src.a[k*GROUP_W +: GROUP_W]),
            .nb   (src.nb[k*GROUP_W +: GROUP_W]),
            .cin  (src.carry),
            .sum  (grp_sum),
            .cout (grp_cout),
            .g    (grp_g),
            .p    (grp_p)
        );

        always_comb begin
            diff_next = src.diff;
            diff_next[k*GROUP_W +: GROUP_W] = grp_sum;
        end

        // cout and G | P&cin are the same function; both views feed the next stage.
        assign carry_next = grp_cout | grp_g | (grp_p & src.carry);

        assign stage_d[k] = '{valid: src.valid, diff: diff_next, a: src.a, nb: src.nb,
                              carry: carry_next, a_msb: src.a_msb, b_msb: src.b_msb};
    end

    always_comb begin
        flags_d        = '0;
        flags_d.borrow = ~stage_d[STAGES-1].carry;
        flags_d.ovf    = sub_overflow(stage_d[STAGES-1].a_msb, stage_d[STAGES-1].b_msb,
                                      stage_d[STAGES-1].diff[WIDTH-1]);
        flags_d.zero   = (stage_d[STAGES-1].diff == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            flags_q <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            flags_q <= flags_d;
        end
    end

    assign bus.out_valid  = stage_q[STAGES-1].valid;
    assign bus.out_diff   = stage_q[STAGES-1].diff;
    assign bus.out_borrow = flags_q.borrow;
    assign bus.out_ovf    = flags_q.ovf;
    assign bus.out_zero   = flags_q.zero;

endmodule

// File: tb/tb_cla_pipe_subtractor.sv
// Self-checking bench for cla_pipe_subtractor (WIDTH=16): directed boundaries, burst,
// back-pressure, mid-flight reset and a long random run against an arithmetic model.
module tb_cla_pipe_subtractor;

    typedef struct {
        logic [15:0] diff;
        logic        borrow;
        logic        ovf;
        logic        zero;
        int          edge_acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cla_pipe_subtractor_if #(.WIDTH(16)) bus ();

    cla_pipe_subtractor #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   edge_cnt     = 0;
    bit   check_latency = 1'b0;
    bit   accepted;
    exp_t cur_exp;
    exp_t exp_q [$];
    int   result_edges [$];

    logic [15:0] dir_a [9] = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'hABCD,
                               16'h5A5A, 16'h0000, 16'h8000, 16'h0010};
    logic [15:0] dir_b [9] = '{16'h0034, 16'h0001, 16'h0001, 16'hFFFF, 16'hABCD,
                               16'h0000, 16'h8000, 16'h8000, 16'h0001};
    logic [15:0] dir_d [9] = '{16'h1200, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000,
                               16'h5A5A, 16'h8000, 16'h0000, 16'h000F};
    logic        dir_bo [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        dir_ov [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        dir_z  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
    function automatic exp_t refSub(input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        int   ua, ub, sa, sb, sd;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb;
        r.diff     = 16'((ua - ub + 65536) % 65536);
        r.borrow   = (ua < ub);
        r.ovf      = (sd > 32767) || (sd < -32768);
        r.zero     = (a == b);
        r.edge_acc = 0;
        return r;
    endfunction

    function automatic logic [15:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, observed, expected, edge_cnt);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [15:0] a, input logic [15:0] b, input bit oready);
        bus.in_valid  = valid;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = oready;
        cur_exp       = refSub(a, b);
        #1;
    endtask

    task automatic applyDirected(input int i);
        applyStimulus(1'b1, dir_a[i], dir_b[i], 1'b1);
        cur_exp.diff   = dir_d[i];
        cur_exp.borrow = dir_bo[i];
        cur_exp.ovf    = dir_ov[i];
        cur_exp.zero   = dir_z[i];
    endtask

    // One clock: score any output transfer, log any input accept, cross the edge.
    task automatic tick();
        exp_t e;
        bit   rst_now;
        #1;
        rst_now = rst;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 32'(bus.out_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                checkOutput("diff",   32'(bus.out_diff),   32'(e.diff));
                checkOutput("borrow", 32'(bus.out_borrow), 32'(e.borrow));
                checkOutput("ovf",    32'(bus.out_ovf),    32'(e.ovf));
                checkOutput("zero",   32'(bus.out_zero),   32'(e.zero));
                if (check_latency) checkOutput("latency", 32'(edge_cnt - e.edge_acc), 32'(4));
                result_edges.push_back(edge_cnt);
            end
        end
        accepted = (bus.in_valid === 1'b1 && bus.in_ready === 1'b1);
        if (accepted) begin
            e          = cur_exp;
            e.edge_acc = edge_cnt;
            exp_q.push_back(e);
        end
        @(posedge clk);
        edge_cnt++;
        if (rst_now) exp_q.delete();
        @(negedge clk);
    endtask

    task automatic drainAll(input int bound);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < bound && exp_q.size() > 0; i++) tick();
        checkOutput("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at edge %0d", edge_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] sa [16];
        logic [15:0] sb [16];
        logic [15:0] held;
        logic [15:0] pa, pb;
        int          idx;
        int          done;
        bit          stall;

        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(bus.out_valid),  32'(0));
        checkOutput("rst_out_diff",  32'(bus.out_diff),   32'(0));
        checkOutput("rst_borrow",    32'(bus.out_borrow), 32'(0));
        checkOutput("rst_ovf",       32'(bus.out_ovf),    32'(0));
        checkOutput("rst_zero",      32'(bus.out_zero),   32'(0));
        checkOutput("rst_in_ready",  32'(bus.in_ready),   32'(0));
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'(1));

        $display("[TB] single op and boundary operands");
        check_latency = 1'b1;
        applyDirected(0);
        tick();
        drainAll(20);
        for (int i = 1; i < 8; i++) begin
            applyDirected(i);
            tick();
        end
        drainAll(20);

        $display("[TB] back-to-back burst of 8");
        result_edges.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, pickOperand(), pickOperand(), 1'b1);
            checkOutput("burst_in_ready", 32'(bus.in_ready), 32'(1));
            tick();
        end
        drainAll(20);
        checkOutput("burst_count", 32'(result_edges.size()), 32'(8));
        for (int i = 1; i < result_edges.size(); i++)
            checkOutput("burst_consecutive", 32'(result_edges[i] - result_edges[i-1]), 32'(1));

        $display("[TB] stream with 5-cycle output stall");
        check_latency = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
        end
        idx  = 0;
        held = 16'h0;
        for (int t = 0; t < 80 && (idx < 16 || exp_q.size() > 0); t++) begin
            stall = (t >= 8 && t < 13);
            applyStimulus(idx < 16, sa[idx < 16 ? idx : 15], sb[idx < 16 ? idx : 15], !stall);
            if (stall) begin
                checkOutput("stall_in_ready",  32'(bus.in_ready),  32'(0));
                checkOutput("stall_out_valid", 32'(bus.out_valid), 32'(1));
                if (t == 8) held = bus.out_diff;
                else        checkOutput("stall_diff_stable", 32'(bus.out_diff), 32'(held));
            end
            tick();
            if (accepted) idx++;
        end
        checkOutput("stream_accepted", 32'(idx), 32'(16));
        checkOutput("stream_drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] reset with tokens in flight");
        check_latency = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1);
            tick();
        end
        rst = 1'b1;
        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b1);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'(0));
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("no_out_after_rst", 32'(bus.out_valid), 32'(0));
            tick();
        end
        applyDirected(8);
        tick();
        drainAll(20);

        $display("[TB] random traffic, 10000 operations");
        check_latency = 1'b0;
        done = 0;
        pa = pickOperand();
        pb = ($urandom_range(0, 9) == 0) ? pa : pickOperand();
        for (int cyc = 0; cyc < 60000 && done < 10000; cyc++) begin
            applyStimulus($urandom_range(0, 3) != 0, pa, pb, $urandom_range(0, 3) != 0);
            tick();
            if (accepted) begin
                done++;
                pa = pickOperand();
                pb = ($urandom_range(0, 9) == 0) ? pa : pickOperand();
            end
        end
        checkOutput("random_ops_done", 32'(done), 32'(10000));
        drainAll(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
